// File: rtl/dmem_bytelane_if.sv
// ---------------------------------------------------------------------------
// dmem_bytelane_if
// Request/response bundle between the core's MEM stage and the data memory.
//
//   req_valid    core -> mem   request present
//   req_ready    mem  -> core  memory accepts a request this cycle
//   req_we       core -> mem   1 = store, 0 = load
//   req_size     core -> mem   00 byte, 01 half, 10/11 word
//   req_unsigned core -> mem   loads: 1 = zero-extend, 0 = sign-extend
//   req_addr     core -> mem   byte address
//   req_wdata    core -> mem   right-aligned store data
//   rsp_valid    mem  -> core  one-cycle pulse per accepted request
//   rsp_rdata    mem  -> core  extended load data, 0 otherwise
//   rsp_err      mem  -> core  request was rejected (range / alignment)
//
// master: the requester (core). slave: the memory.
// ---------------------------------------------------------------------------
interface dmem_bytelane_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_bytelane.sv
// ---------------------------------------------------------------------------
// dmem_bytelane
// Byte-lane data memory for the MIPS core. Byte/half/word loads and stores
// with sign/zero extension, valid/ready request port and a registered
// one-cycle response. After reset a clear sequencer writes CLR_VAL to one
// word per cycle; requests are refused until it finishes.
//
// Parameters:
//   BASE_ADDR    byte address of word 0
//   DEPTH_WORDS  number of 32-bit words (power of two, >= 4)
//   CLR_VAL      value written to every word by the clear sequencer
//
// Ports:
//   clk          clock, all state changes on posedge
//   rst          asynchronous, active-high reset; restarts the clear sequence
//   bus          dmem_bytelane_if.slave request/response port
//   init_busy    clear sequence in progress
//
// Build option:
//   DMEM_ALIGN_CHECK_EN  when defined, misaligned half/word accesses are
//                        rejected with rsp_err. When undefined, low address
//                        bits below the access size are ignored.
// ---------------------------------------------------------------------------
module dmem_bytelane #(
    parameter logic [31:0] BASE_ADDR   = 32'h1001_0000,
    parameter int unsigned DEPTH_WORDS = 2048,
    parameter logic [31:0] CLR_VAL     = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             rst,
    dmem_bytelane_if.slave   bus,
    output logic             init_busy
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN  = 32'(DEPTH_WORDS * 4);

    typedef enum logic {
        ST_CLEAR,
        ST_RUN
    } state_t;

    state_t            state;
    logic [IDX_W-1:0]  clr_idx;
    logic              ready_q;
    logic              busy_q;
    logic              rsp_valid_q;
    logic [31:0]       rsp_rdata_q;
    logic              rsp_err_q;

    logic [31:0]       mem [DEPTH_WORDS];

    // ---------------------------------------------------------------------
    // Address decode
    // ---------------------------------------------------------------------
    logic [31:0]       off;
    logic              in_range;
    logic [IDX_W-1:0]  word_idx;
    logic [1:0]        lane;
    logic              misalign;
    logic              req_err;
    logic              accept;

    // Modulo-2^32 subtraction: addresses below the base wrap to huge offsets
    // and fail the unsigned range compare.
    assign off      = bus.req_addr - BASE_ADDR;
    assign in_range = (off < SPAN);
    assign word_idx = off[IDX_W+1:2];
    assign lane     = off[1:0];

`ifdef DMEM_ALIGN_CHECK_EN
    // size 11 is treated as a word, so req_size[1] covers both word codes.
    assign misalign = ((bus.req_size == 2'b01) && off[0]) ||
                      (bus.req_size[1] && (off[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    assign req_err = !in_range || misalign;
    assign accept  = bus.req_valid && ready_q;

    // ---------------------------------------------------------------------
    // Lane steering for stores and load extraction
    // ---------------------------------------------------------------------
    logic [31:0] rd_word;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [3:0]  be;
    logic [31:0] wdata_rep;
    logic [31:0] ld_data;

    // Combinational read: a store on one edge is visible to a load accepted
    // on the next edge without any bypass path.
    assign rd_word = mem[word_idx];
    assign rd_byte = rd_word[{lane, 3'b000} +: 8];
    assign rd_half = off[1] ? rd_word[31:16] : rd_word[15:0];

    // NOTE: every output of this block gets a default first so no path
    // through the case leaves a signal unassigned and infers a latch.
    always_comb begin
        be        = 4'b1111;
        wdata_rep = bus.req_wdata;
        ld_data   = rd_word;
        case (bus.req_size)
            2'b00: begin
                be        = 4'b0001 << lane;
                wdata_rep = {4{bus.req_wdata[7:0]}};
                ld_data   = bus.req_unsigned ? {24'h0, rd_byte}
                                             : {{24{rd_byte[7]}}, rd_byte};
            end
            2'b01: begin
                // off[0] is ignored here: half lanes are {off[1],0}/{off[1],1}.
                be        = off[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{bus.req_wdata[15:0]}};
                ld_data   = bus.req_unsigned ? {16'h0, rd_half}
                                             : {{16{rd_half[15]}}, rd_half};
            end
            default: begin
                be        = 4'b1111;
                wdata_rep = bus.req_wdata;
                ld_data   = rd_word;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Storage array
    // ---------------------------------------------------------------------
    // NOTE: the array has no reset term; it is initialised by the clear
    // sequencer one word per cycle, which keeps it mappable to RAM.
    always_ff @(posedge clk) begin
        if (state == ST_CLEAR) begin
            mem[clr_idx] <= CLR_VAL;
        end else if (accept && bus.req_we && !req_err) begin
            for (int l = 0; l < 4; l++) begin
                if (be[l]) begin
                    mem[word_idx][8*l +: 8] <= wdata_rep[8*l +: 8];
                end
            end
        end
    end

    // ---------------------------------------------------------------------
    // Control FSM with registered outputs
    // ---------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_CLEAR;
            clr_idx     <= '0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= accept;
            rsp_err_q   <= accept && req_err;
            rsp_rdata_q <= (accept && !bus.req_we && !req_err) ? ld_data : 32'h0;

            case (state)
                ST_CLEAR: begin
                    clr_idx <= clr_idx + IDX_W'(1);
                    if (&clr_idx) begin
                        state   <= ST_RUN;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state <= ST_CLEAR;
                end
            endcase
        end
    end

    assign bus.req_ready = ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign init_busy     = busy_q;

endmodule

// File: tb/tb_dmem_bytelane.sv
// ---------------------------------------------------------------------------
// tb_dmem_bytelane
// Directed bench for dmem_bytelane with DEPTH_WORDS=16 and the default base.
// Covers the clear sequence, byte/half/word stores and loads with extension,
// write-then-read, range errors, alignment behaviour (both builds of
// DMEM_ALIGN_CHECK_EN) and reset during a store stream.
// ---------------------------------------------------------------------------
module tb_dmem_bytelane;

    localparam logic [31:0] BASE  = 32'h1001_0000;
    localparam int          DEPTH = 16;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_R = 2'b11;

    logic clk = 1'b0;
    logic rst;
    logic init_busy;

    dmem_bytelane_if bus ();

    dmem_bytelane #(
        .BASE_ADDR   (BASE),
        .DEPTH_WORDS (DEPTH),
        .CLR_VAL     (32'h0000_0000)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .init_busy (init_busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle();
        bus.req_valid    = 1'b0;
        bus.req_we       = 1'b0;
        bus.req_size     = SZ_W;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 32'h0;
        bus.req_wdata    = 32'h0;
    endtask

    task automatic drive(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata);
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
    endtask

    // One accepted request: drive, take the accept edge, check the response
    // #1 later. Consecutive calls are back-to-back requests.
    task automatic xfer(input string tag, input logic we, input logic [1:0] size,
                        input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err);
        drive(we, size, uns, addr, wdata);
        @(posedge clk);
        #1;
        check({tag, ".valid"}, 32'(bus.rsp_valid), 32'd1);
        check({tag, ".rdata"}, bus.rsp_rdata, exp_rdata);
        check({tag, ".err"},   32'(bus.rsp_err), 32'(exp_err));
        bus.req_valid = 1'b0;
    endtask

    // Counts cycles until req_ready, bounded; no response may appear meanwhile.
    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!bus.req_ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
            check({tag, ".norsp"}, 32'(bus.rsp_valid), 32'd0);
        end
        check({tag, ".len"},  32'(n), 32'(DEPTH));
        check({tag, ".busy"}, 32'(init_busy), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        #1;
        check("rst.rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst.rsp_rdata", bus.rsp_rdata, 32'h0);
        check("rst.rsp_err",   32'(bus.rsp_err), 32'd0);
        check("rst.ready",     32'(bus.req_ready), 32'd0);
        check("rst.busy",      32'(init_busy), 32'd1);

        // Release reset between edges and hold a store during the clear:
        // it must be ignored and never produce a response.
        rst = 1'b0;
        check("clr1.busy0",  32'(init_busy), 32'd1);
        check("clr1.ready0", 32'(bus.req_ready), 32'd0);
        drive(1'b1, SZ_W, 1'b0, BASE, 32'hDEAD_BEEF);
        wait_ready("clr1");
        idle();

        xfer("lw_08",     1'b0, SZ_W, 1'b0, BASE + 32'h08, 32'h0, 32'h0000_0000, 1'b0);
        xfer("lw_00_ign", 1'b0, SZ_W, 1'b0, BASE + 32'h00, 32'h0, 32'h0000_0000, 1'b0);

        // Word store then byte merge into lane 2.
        xfer("sw_04",   1'b1, SZ_W, 1'b0, BASE + 32'h04, 32'h1122_3344, 32'h0, 1'b0);
        xfer("sb_06",   1'b1, SZ_B, 1'b0, BASE + 32'h06, 32'h1234_56AB, 32'h0, 1'b0);
        xfer("lw_04",   1'b0, SZ_W, 1'b0, BASE + 32'h04, 32'h0, 32'h11AB_3344, 1'b0);
        xfer("lb_06",   1'b0, SZ_B, 1'b0, BASE + 32'h06, 32'h0, 32'hFFFF_FFAB, 1'b0);
        xfer("lbu_06",  1'b0, SZ_B, 1'b1, BASE + 32'h06, 32'h0, 32'h0000_00AB, 1'b0);
        xfer("lb_04",   1'b0, SZ_B, 1'b0, BASE + 32'h04, 32'h0, 32'h0000_0044, 1'b0);
        xfer("lb_07",   1'b0, SZ_B, 1'b0, BASE + 32'h07, 32'h0, 32'h0000_0011, 1'b0);
        xfer("lh_06",   1'b0, SZ_H, 1'b0, BASE + 32'h06, 32'h0, 32'h0000_11AB, 1'b0);
        xfer("lw11_04", 1'b0, SZ_R, 1'b1, BASE + 32'h04, 32'h0, 32'h11AB_3344, 1'b0);

        // Half store into upper lanes, read back on the very next cycle.
        xfer("sw_00",  1'b1, SZ_W, 1'b0, BASE + 32'h00, 32'hA5A5_5A5A, 32'h0, 1'b0);
        xfer("sh_02",  1'b1, SZ_H, 1'b0, BASE + 32'h02, 32'hCAFE_8001, 32'h0, 1'b0);
        xfer("lh_02",  1'b0, SZ_H, 1'b0, BASE + 32'h02, 32'h0, 32'hFFFF_8001, 1'b0);
        xfer("lhu_02", 1'b0, SZ_H, 1'b1, BASE + 32'h02, 32'h0, 32'h0000_8001, 1'b0);
        xfer("lw_00",  1'b0, SZ_W, 1'b0, BASE + 32'h00, 32'h0, 32'h8001_5A5A, 1'b0);

        // Range boundaries.
        xfer("lw_40",   1'b0, SZ_W, 1'b0, BASE + 32'h40,  32'h0, 32'h0, 1'b1);
        xfer("lw_below",1'b0, SZ_W, 1'b0, 32'h1000_FFFC,  32'h0, 32'h0, 1'b1);
        xfer("sw_40",   1'b1, SZ_W, 1'b0, BASE + 32'h40,  32'hFFFF_FFFF, 32'h0, 1'b1);
        xfer("lw_00b",  1'b0, SZ_W, 1'b0, BASE + 32'h00,  32'h0, 32'h8001_5A5A, 1'b0);
        xfer("sw_3c",   1'b1, SZ_W, 1'b0, BASE + 32'h3C,  32'h0BAD_F00D, 32'h0, 1'b0);
        xfer("lw_3c",   1'b0, SZ_W, 1'b0, BASE + 32'h3C,  32'h0, 32'h0BAD_F00D, 1'b0);

        // Misaligned accesses.
`ifdef DMEM_ALIGN_CHECK_EN
        xfer("lw_05",   1'b0, SZ_W, 1'b0, BASE + 32'h05, 32'h0, 32'h0, 1'b1);
        xfer("lh_07",   1'b0, SZ_H, 1'b0, BASE + 32'h07, 32'h0, 32'h0, 1'b1);
        xfer("sw_05",   1'b1, SZ_W, 1'b0, BASE + 32'h05, 32'h0, 32'h0, 1'b1);
        xfer("lw_04b",  1'b0, SZ_W, 1'b0, BASE + 32'h04, 32'h0, 32'h11AB_3344, 1'b0);
`else
        xfer("lw_05",   1'b0, SZ_W, 1'b0, BASE + 32'h05, 32'h0, 32'h11AB_3344, 1'b0);
        xfer("lh_07",   1'b0, SZ_H, 1'b0, BASE + 32'h07, 32'h0, 32'h0000_11AB, 1'b0);
`endif

        // Reset in the middle of a back-to-back store stream.
        xfer("sw_08", 1'b1, SZ_W, 1'b0, BASE + 32'h08, 32'h0101_0101, 32'h0, 1'b0);
        xfer("sw_0c", 1'b1, SZ_W, 1'b0, BASE + 32'h0C, 32'h0202_0202, 32'h0, 1'b0);
        drive(1'b1, SZ_W, 1'b0, BASE + 32'h10, 32'h0303_0303);
        #3;
        rst = 1'b1;
        #1;
        check("rst2.rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst2.ready",     32'(bus.req_ready), 32'd0);
        check("rst2.busy",      32'(init_busy), 32'd1);
        repeat (2) begin
            @(posedge clk);
            #1;
            check("rst2.hold", 32'(bus.rsp_valid), 32'd0);
        end
        rst = 1'b0;
        wait_ready("clr2");
        idle();

        for (int i = 0; i < DEPTH; i++) begin
            xfer($sformatf("scan_%0d", i), 1'b0, SZ_W, 1'b0, BASE + 32'(4 * i),
                 32'h0, 32'h0000_0000, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/dmem_bytelane.md
Name: dmem_bytelane

Overview:
- Parametrised data memory for the MIPS core. Supports byte, halfword and word loads/stores with sign/zero extension.
- Uses a valid/ready request port and a registered (1-cycle) response.
- After reset, a hardware clear sequencer zeroes the array one word per cycle, so the reset path never needs a combinational full-array loop.
- Sits between the core's MEM stage and the data segment at BASE_ADDR.

Parameters:
- BASE_ADDR, 32'h1001_0000, byte address of word 0; subtracted from req_addr.
- DEPTH_WORDS, 2048, number of 32-bit words; power of two, at least 4.
- CLR_VAL, 32'h0000_0000, value written to every word by the clear sequencer.

Ports:
- clk, input, 1: clock; all state changes on posedge.
- rst, input, 1: reset, asynchronous, active-high.
- req_valid, input, 1: request present.
- req_ready, output, 1: block accepts a request this cycle.
- req_we, input, 1: 1 = store, 0 = load.
- req_size, input, 2: 00 byte, 01 half, 10 word, 11 reserved (treated as word).
- req_unsigned, input, 1: loads only; 1 = zero-extend, 0 = sign-extend.
- req_addr, input, 32: byte address.
- req_wdata, input, 32: store data, right-aligned (byte in [7:0], half in [15:0]).
- rsp_valid, output, 1: one-cycle pulse for each accepted request.
- rsp_rdata, output, 32: load result, extended; 0 for stores and errors.
- rsp_err, output, 1: qualifies rsp_valid; address out of range (or misaligned, see macro).
- init_busy, output, 1: clear sequence in progress.

Behaviour:
- Reset (async, rst=1): state CLEAR, clear index 0, req_ready=0, init_busy=1, rsp_valid=0, rsp_rdata=0, rsp_err=0. Any in-flight response is dropped.
- CLEAR state:
  - Each cycle writes CLR_VAL to word[idx] and increments idx.
  - After the write to DEPTH_WORDS-1, moves to RUN on the next edge. Clear takes exactly DEPTH_WORDS cycles after rst deasserts.
  - req_ready=0 throughout; requests are ignored, not queued.
- RUN state:
  - req_ready=1 and init_busy=0 every cycle.
  - Accept = req_valid & req_ready; at most one request per cycle.
- Address decode:
  - off = req_addr - BASE_ADDR (32-bit, modulo 2^32).
  - In range iff off < DEPTH_WORDS*4, compared unsigned, so addresses below the base wrap high and count as out of range.
  - word index = off[log2(DEPTH_WORDS)+1:2]; lane = off[1:0].
- Byte lanes (little-endian): lane 0 = bits [7:0] … lane 3 = bits [31:24].
  - Byte accesses use lane off[1:0].
  - Half accesses use lanes {off[1],0} and {off[1],1}.
  - Word accesses use all 4 lanes.
- Store: on the accept edge, only the selected lanes of the word are written with replicated req_wdata. Unselected lanes are unchanged.
- Load: the selected lanes are read at the accept edge, right-aligned, and sign- or zero-extended per req_unsigned. Word loads ignore req_unsigned.
- Response timing: rsp_valid=1 exactly on the cycle after accept, with rsp_rdata and rsp_err. In the following cycle, rsp_valid=0 unless another request was accepted.
  - Back-to-back accepts give back-to-back responses; there is no backpressure on the response side.
- Error: out-of-range request gives no write, rsp_err=1, rsp_rdata=0.
- Write-then-read of the same word in consecutive cycles: the read returns the newly written data.
- rsp_rdata is held at 0 whenever rsp_valid=0.
- Reset mid-operation (RUN or mid-CLEAR): the clear restarts at index 0, and all prior contents are overwritten with CLR_VAL.

Optional Feature:
- Macro DMEM_ALIGN_CHECK_EN.
- Defined: a half access with off[0]=1, or a word access with off[1:0]≠0, is misaligned. Misaligned requests give no write, rsp_err=1, rsp_rdata=0; an out-of-range condition also sets rsp_err.
- Undefined: no alignment check. Low address bits below the access size are ignored (forced alignment), and rsp_err reflects range only.

Test Plan:
- Use DEPTH_WORDS=16. Pulse rst, then release: init_busy=1 and req_ready=0 for exactly 16 cycles, then req_ready=1. A word load at 0x1001_0008 returns 0x0000_0000.
- sw 0x1122_3344 @0x1001_0004, then sb 0xAB @0x1001_0006. Expect:
  - lw @0x1001_0004 → 0x11AB_3344
  - lb @0x1001_0006 → 0xFFFF_FFAB
  - lbu @0x1001_0006 → 0x0000_00AB
- sh 0x8001 @0x1001_0002, then next cycle lh @0x1001_0002 → 0xFFFF_8001 and lhu → 0x0000_8001. Lanes 0–1 are unchanged.
- lw @0x1001_0040 (off=64 ≥ 64) and lw @0x1000_FFFC → both give rsp_err=1, rsp_rdata=0. sw to 0x1001_0040 does not alter word 0.
- With DMEM_ALIGN_CHECK_EN, lw @0x1001_0005 → rsp_err=1. Without it, the same lw returns word 1 with rsp_err=0.
- Assert rst during a stream of 3 back-to-back stores. Expect no rsp_valid after the reset edge, the clear rerun, and all words reading 0.
